// File: rtl/uart_pkg.sv
// Shared definitions for the UART controller: register map, bit positions
// inside CTRL/STATUS/IE, and the encodings used by both serial engines.
package uart_pkg;

  localparam logic [2:0] ADDR_DIV_LO = 3'd0;
  localparam logic [2:0] ADDR_DIV_HI = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_TXDATA = 3'd4;
  localparam logic [2:0] ADDR_RXDATA = 3'd5;
  localparam logic [2:0] ADDR_IE     = 3'd6;

  localparam int CTRL_TX_EN    = 0;
  localparam int CTRL_RX_EN    = 1;
  localparam int CTRL_PAR_EN   = 2;
  localparam int CTRL_PAR_ODD  = 3;
  localparam int CTRL_TWO_STOP = 4;
  localparam int CTRL_LOOPBACK = 5;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_RX_OVR   = 5;
  localparam int ST_PAR_ERR  = 6;
  localparam int ST_FRM_ERR  = 7;

  localparam int IE_RX_AVAIL = 0;
  localparam int IE_TX_EMPTY = 1;
  localparam int IE_ERR      = 2;

  // Common encoding for the TX and RX state machines.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word-fall-through output. Push when full and
// pop when empty are ignored, judged on the state before the clock edge.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_ctrl.sv
// UART controller: register bus, programmable baud divisor and frame format,
// TX/RX FIFOs, inline TX and RX engines, level interrupt.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] address,
  input  logic [7:0] w_data,
  input  logic       write,
  input  logic       read,
  output logic [7:0] r_data,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);
  localparam int         HI_W     = DIV_WIDTH - 8;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic [7:0]           div_lo;
  logic [HI_W-1:0]      div_hi;
  logic [5:0]           ctrl;
  logic [2:0]           ie;
  logic                 rx_ovr, par_err, frm_err;
  logic [DIV_WIDTH-1:0] div_full, bit_div;
  logic                 rd_en;
  logic [7:0]           w1c, status, rd_mux;

  assign div_full = {div_hi, div_lo};
  assign bit_div  = (div_full < DIV_WIDTH'(3)) ? DIV_WIDTH'(3) : div_full;
  assign rd_en    = read && !write;
  assign w1c      = (write && address == ADDR_STATUS) ? w_data : 8'h00;

  // ---------------- TX path ----------------
  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_dout, tx_shift;
  logic [2:0]           tx_state, tx_idx;
  logic [DIV_WIDTH-1:0] tx_cnt;
  logic                 tx_tick, tx_par, tx_stop2, tx_bit, tx_q;

  assign tx_push = write && address == ADDR_TXDATA;
  assign tx_pop  = (tx_state == S_IDLE) && ctrl[CTRL_TX_EN] && !tx_empty;
  assign tx_tick = (tx_cnt == '0);
  assign tx      = tx_q;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk, .reset_n, .push(tx_push), .pop(tx_pop), .din(w_data[DATA_BITS-1:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  // tx_bit is the line value chosen at each bit boundary; tx_q retimes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_idx   <= '0;
      tx_par   <= 1'b0;
      tx_stop2 <= 1'b0;
      tx_bit   <= 1'b1;
      tx_q     <= 1'b1;
    end else begin
      tx_q <= tx_bit;
      if (tx_state != S_IDLE) tx_cnt <= tx_tick ? bit_div : tx_cnt - DIV_WIDTH'(1);
      case (tx_state)
        S_IDLE: if (tx_pop) begin
          tx_state <= S_START;
          tx_cnt   <= bit_div;
          tx_shift <= tx_dout;
          tx_par   <= 1'b0;
          tx_bit   <= 1'b0;
        end
        S_START: if (tx_tick) begin
          tx_state <= S_DATA;
          tx_idx   <= '0;
          tx_bit   <= tx_shift[0];
        end
        S_DATA: if (tx_tick) begin
          tx_par   <= tx_par ^ tx_shift[0];
          tx_shift <= tx_shift >> 1;
          if (tx_idx == LAST_BIT) begin
            if (ctrl[CTRL_PAR_EN]) begin
              tx_state <= S_PARITY;
              tx_bit   <= tx_par ^ tx_shift[0] ^ ctrl[CTRL_PAR_ODD];
            end else begin
              tx_state <= S_STOP;
              tx_bit   <= 1'b1;
              tx_stop2 <= ctrl[CTRL_TWO_STOP];
            end
          end else begin
            tx_idx <= tx_idx + 3'd1;
            tx_bit <= tx_shift[1];
          end
        end
        S_PARITY: if (tx_tick) begin
          tx_state <= S_STOP;
          tx_bit   <= 1'b1;
          tx_stop2 <= ctrl[CTRL_TWO_STOP];
        end
        S_STOP: if (tx_tick) begin
          if (tx_stop2) tx_stop2 <= 1'b0;
          else          tx_state <= S_IDLE;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_src, rx_s, rx_prev;
  logic [2:0]             rx_state, rx_idx;
  logic [DIV_WIDTH-1:0]   rx_cnt;
  logic [DATA_BITS-1:0]   rx_shift, rx_dout;
  logic                   rx_tick, rx_par_bad, rx_push, rx_pop, rx_full, rx_empty;

  assign rx_src  = ctrl[CTRL_LOOPBACK] ? tx_q : rx;
  assign rx_s    = rx_sync[SYNC_STAGES-1];
  assign rx_tick = (rx_cnt == '0);
  assign rx_push = ctrl[CTRL_RX_EN] && rx_state == S_STOP && rx_tick;
  assign rx_pop  = rd_en && address == ADDR_RXDATA;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk, .reset_n, .push(rx_push), .pop(rx_pop), .din(rx_shift),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync    <= '1;
      rx_prev    <= 1'b1;
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_shift   <= '0;
      rx_idx     <= '0;
      rx_par_bad <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx_src};
      rx_prev <= rx_s;
      if (!ctrl[CTRL_RX_EN]) begin
        rx_state <= S_IDLE;
      end else begin
        if (rx_state != S_IDLE) rx_cnt <= rx_tick ? bit_div : rx_cnt - DIV_WIDTH'(1);
        case (rx_state)
          S_IDLE: if (rx_prev && !rx_s) begin
            rx_state   <= S_START;
            rx_cnt     <= bit_div >> 1;
            rx_par_bad <= 1'b0;
          end
          S_START: if (rx_tick) begin
            rx_state <= rx_s ? S_IDLE : S_DATA;
            rx_idx   <= '0;
          end
          S_DATA: if (rx_tick) begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            if (rx_idx == LAST_BIT) rx_state <= ctrl[CTRL_PAR_EN] ? S_PARITY : S_STOP;
            else                    rx_idx   <= rx_idx + 3'd1;
          end
          S_PARITY: if (rx_tick) begin
            rx_par_bad <= rx_s ^ (^rx_shift) ^ ctrl[CTRL_PAR_ODD];
            rx_state   <= S_STOP;
          end
          S_STOP: if (rx_tick) rx_state <= S_IDLE;
          default: rx_state <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------- Registers and bus ----------------
  always_comb begin
    status              = 8'h00;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_TX_BUSY]  = (tx_state != S_IDLE);
    status[ST_RX_OVR]   = rx_ovr;
    status[ST_PAR_ERR]  = par_err;
    status[ST_FRM_ERR]  = frm_err;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (address)
      ADDR_DIV_LO: rd_mux = div_lo;
      ADDR_DIV_HI: rd_mux = 8'(div_hi);
      ADDR_CTRL:   rd_mux = {2'b00, ctrl};
      ADDR_STATUS: rd_mux = status;
      ADDR_RXDATA: rd_mux = rx_empty ? 8'h00 : 8'(rx_dout);
      ADDR_IE:     rd_mux = {5'b00000, ie};
      default:     rd_mux = 8'h00;
    endcase
  end

  // Error flags: a new error on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_lo  <= '0;
      div_hi  <= '0;
      ctrl    <= '0;
      ie      <= '0;
      rx_ovr  <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      r_data  <= '0;
    end else begin
      if (write) begin
        case (address)
          ADDR_DIV_LO: div_lo <= w_data;
          ADDR_DIV_HI: div_hi <= w_data[HI_W-1:0];
          ADDR_CTRL:   ctrl   <= w_data[5:0];
          ADDR_IE:     ie     <= w_data[2:0];
          default: ;
        endcase
      end
      rx_ovr  <= (rx_ovr  & ~w1c[ST_RX_OVR])  | (rx_push & rx_full);
      par_err <= (par_err & ~w1c[ST_PAR_ERR]) | (rx_push & rx_par_bad);
      frm_err <= (frm_err & ~w1c[ST_FRM_ERR]) | (rx_push & !rx_s);
      if (rd_en) r_data <= rd_mux;
    end
  end

  assign irq = (ie[IE_RX_AVAIL] & !rx_empty) | (ie[IE_TX_EMPTY] & tx_empty) |
               (ie[IE_ERR] & (rx_ovr | par_err | frm_err));

endmodule

// File: tb/tb_uart_ctrl.sv
// Testbench for uart_ctrl: bus reads are checked by a scoreboard fed from a
// frame-level reference model; pin-level checks cover tx framing, irq, reset.
`timescale 1ns/1ps
module tb_uart_ctrl;
  import uart_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] address;
  logic [7:0] w_data;
  logic       write, read;
  logic [7:0] r_data;
  logic       rx, tx, irq;

  uart_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .w_data(w_data),
    .write(write), .read(read), .r_data(r_data), .rx(rx), .tx(tx), .irq(irq)
  );

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard and model state ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] msk_q[$];
  string      tag_q[$];
  logic       rd_q = 1'b0;

  logic [7:0]  mdl_rx[$];
  logic [7:0]  mdl_tx[$];
  logic        mdl_ovr = 1'b0, mdl_par = 1'b0, mdl_frm = 1'b0;
  logic [15:0] cur_div = 16'd0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(posedge clk) rd_q <= reset_n && read && !write;

  always @(negedge clk) begin : monitor
    logic [7:0] e, m;
    string t;
    if (rd_q) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read: got %h expected no read", r_data);
      end else begin
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        t = tag_q.pop_front();
        if ((r_data & m) !== (e & m)) begin
          n_err++;
          $display("FAIL %s: got %h expected %h (mask %h)", t, r_data & m, e & m, m);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int period();
    return ((cur_div < 16'd3) ? 3 : int'(cur_div)) + 1;
  endfunction

  function automatic logic [15:0] frame_bits(input logic [7:0] d, input bit pe, input bit po);
    logic [15:0] b;
    b = 16'hFFFF;
    b[0] = 1'b0;
    b[8:1] = d;
    if (pe) b[9] = (^d) ^ po;
    return b;
  endfunction

  task automatic mdl_rx_in(input logic [7:0] d, input bit par_bad, input bit stop_bad);
    if (par_bad) mdl_par = 1'b1;
    if (stop_bad) mdl_frm = 1'b1;
    if (mdl_rx.size() < DEPTH) mdl_rx.push_back(d);
    else mdl_ovr = 1'b1;
  endtask

  function automatic logic [7:0] mdl_status();
    logic [7:0] s;
    s = 8'h00;
    s[ST_TX_FULL]  = (mdl_tx.size() == DEPTH);
    s[ST_TX_EMPTY] = (mdl_tx.size() == 0);
    s[ST_RX_FULL]  = (mdl_rx.size() == DEPTH);
    s[ST_RX_EMPTY] = (mdl_rx.size() == 0);
    s[ST_RX_OVR]   = mdl_ovr;
    s[ST_PAR_ERR]  = mdl_par;
    s[ST_FRM_ERR]  = mdl_frm;
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; w_data = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    if (a == ADDR_STATUS) begin
      if (d[ST_RX_OVR])  mdl_ovr = 1'b0;
      if (d[ST_PAR_ERR]) mdl_par = 1'b0;
      if (d[ST_FRM_ERR]) mdl_frm = 1'b0;
    end
    if (a == ADDR_DIV_LO) cur_div[7:0] = d;
    if (a == ADDR_DIV_HI) cur_div[15:8] = d;
    if (a == ADDR_TXDATA && mdl_tx.size() < DEPTH) mdl_tx.push_back(d);
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [7:0] e, input logic [7:0] m, input string t);
    exp_q.push_back(e); msk_q.push_back(m); tag_q.push_back(t);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic rd_rx(input string t);
    logic [7:0] e;
    e = (mdl_rx.size() != 0) ? mdl_rx.pop_front() : 8'h00;
    bus_read(ADDR_RXDATA, e, 8'hFF, t);
  endtask

  task automatic rd_status(input logic [7:0] m, input string t);
    bus_read(ADDR_STATUS, mdl_status(), m, t);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pe, input bit po, input bit flip,
                            input bit stop_val, input bit ts);
    int p;
    p = period();
    @(negedge clk);
    rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (p) @(negedge clk);
    end
    if (pe) begin
      rx = (^d) ^ po ^ flip;
      repeat (p) @(negedge clk);
    end
    rx = stop_val;
    repeat (p) @(negedge clk);
    rx = 1'b1;
    if (ts) repeat (p) @(negedge clk);
    repeat (p) @(negedge clk);
    mdl_rx_in(d, pe && flip, !stop_val);
  endtask

  task automatic capture_tx(input int nbits, output logic [15:0] bits);
    int p, w;
    p = period();
    bits = 16'hFFFF;
    w = 0;
    while (tx !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("tx_start_seen", 16'(tx), 16'h0);
    if (tx === 1'b0) begin
      repeat (p / 2) @(negedge clk);
      bits[0] = tx;
      for (int i = 1; i < nbits; i++) begin
        repeat (p) @(negedge clk);
        bits[i] = tx;
      end
    end
  endtask

  task automatic loopback_frame(input logic [7:0] d, input bit pe, input bit po, input bit ts,
                                output logic [15:0] bits);
    logic [7:0] c;
    c = 8'h23 | {3'b000, ts, po, pe, 2'b00};
    bus_write(ADDR_CTRL, c);
    fork
      capture_tx(10 + int'(pe) + int'(ts), bits);
      bus_write(ADDR_TXDATA, d);
    join
    void'(mdl_tx.pop_front());
    check("tx_frame", bits, frame_bits(d, pe, po));
    mdl_rx_in(d, 1'b0, 1'b0);
    repeat (period() + 10) @(negedge clk);
    rd_rx("loopback_rxdata");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] bits;
    logic [7:0]  d;
    bit          pe, po, ts, fl;
    int          w;

    reset_n = 1'b0; address = '0; w_data = '0; write = 1'b0; read = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", 16'(tx), 16'h1);
    check("reset_irq", 16'(irq), 16'h0);
    check("reset_rdata", 16'(r_data), 16'h0);
    reset_n = 1'b1;

    rd_status(8'hFF, "status_after_reset");
    bus_read(ADDR_CTRL, 8'h00, 8'hFF, "ctrl_after_reset");

    // Register readback and reserved behaviour
    bus_write(ADDR_DIV_HI, 8'hAB);
    bus_read(ADDR_DIV_HI, 8'hAB, 8'hFF, "div_hi_rw");
    bus_write(ADDR_DIV_HI, 8'h00);
    bus_write(ADDR_IE, 8'hFF);
    bus_read(ADDR_IE, 8'h07, 8'hFF, "ie_rw");
    bus_write(ADDR_IE, 8'h00);
    bus_write(3'd7, 8'h55);
    bus_read(3'd7, 8'h00, 8'hFF, "addr7_reads_zero");

    // Loopback of 0xA5 with DIV=9
    bus_write(ADDR_DIV_LO, 8'd9);
    bus_read(ADDR_DIV_LO, 8'd9, 8'hFF, "div_lo_rw");
    loopback_frame(8'hA5, 1'b0, 1'b0, 1'b0, bits);
    check("tx_pattern_a5", bits & 16'h03FF, 16'b0000001101001010);
    rd_status(8'h08, "rx_empty_after_read");

    // Randomised loopback with random frame format and divisor
    for (int k = 0; k < 6; k++) begin
      bus_write(ADDR_DIV_LO, 8'($urandom_range(3, 10)));
      d = 8'($urandom); pe = 1'($urandom); po = 1'($urandom); ts = 1'($urandom);
      loopback_frame(d, pe, po, ts, bits);
      rd_status(8'hEC, "loopback_status");
    end

    // Odd parity with a wrong parity bit
    bus_write(ADDR_DIV_LO, 8'd9);
    bus_write(ADDR_CTRL, 8'h0E);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    rd_rx("parity_err_byte");
    rd_status(8'h40, "par_err_set");
    bus_write(ADDR_STATUS, 8'h40);
    rd_status(8'hE0, "par_err_cleared");

    // Framing error raises irq with IE.err
    bus_write(ADDR_CTRL, 8'h02);
    bus_write(ADDR_IE, 8'h04);
    check("irq_before_frm", 16'(irq), 16'h0);
    send_frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("irq_on_frm_err", 16'(irq), 16'h1);
    rd_rx("frm_err_byte");
    rd_status(8'h80, "frm_err_set");
    bus_write(ADDR_STATUS, 8'hE0);
    bus_write(ADDR_IE, 8'h00);
    check("irq_cleared", 16'(irq), 16'h0);

    // TX FIFO fill with tx disabled, then drain through loopback
    bus_write(ADDR_DIV_LO, 8'd3);
    bus_write(ADDR_CTRL, 8'h00);
    for (int k = 0; k < 5; k++) bus_write(ADDR_TXDATA, 8'($urandom));
    rd_status(8'h03, "tx_full_after_5");
    bus_write(ADDR_CTRL, 8'h23);
    while (mdl_tx.size() != 0) mdl_rx_in(mdl_tx.pop_front(), 1'b0, 1'b0);
    repeat (300) @(negedge clk);
    rd_status(8'hFF, "tx_drained");
    for (int k = 0; k < 5; k++) rd_rx("tx_drain_order");

    // RX overflow: five frames, no reads
    bus_write(ADDR_DIV_LO, 8'd5);
    bus_write(ADDR_CTRL, 8'h02);
    for (int k = 0; k < 5; k++) send_frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rd_status(8'hEC, "rx_overflow");
    bus_write(ADDR_IE, 8'h01);
    check("irq_rx_avail", 16'(irq), 16'h1);
    for (int k = 0; k < 5; k++) rd_rx("rx_fifo_order");
    check("irq_rx_drained", 16'(irq), 16'h0);
    bus_write(ADDR_IE, 8'h02);
    check("irq_tx_empty", 16'(irq), 16'h1);
    bus_write(ADDR_IE, 8'h00);
    bus_write(ADDR_STATUS, 8'hE0);
    rd_status(8'hEC, "ovr_cleared");

    // Randomised RX frames, occasionally with a flipped parity bit
    for (int k = 0; k < 8; k++) begin
      bus_write(ADDR_DIV_LO, 8'($urandom_range(3, 12)));
      d = 8'($urandom); pe = 1'($urandom); po = 1'($urandom); ts = 1'($urandom);
      fl = pe && ($urandom_range(0, 3) == 0);
      bus_write(ADDR_CTRL, 8'h02 | {3'b000, ts, po, pe, 2'b00});
      send_frame(d, pe, po, fl, 1'b1, ts);
      rd_rx("rand_rxdata");
      rd_status(8'hEC, "rand_status");
      bus_write(ADDR_STATUS, 8'hE0);
    end

    // Glitch shorter than half a bit is a false start
    bus_write(ADDR_DIV_LO, 8'd31);
    bus_write(ADDR_CTRL, 8'h02);
    @(negedge clk);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    rd_status(8'hEC, "glitch_ignored");

    // Reset in the middle of a TX frame
    bus_write(ADDR_DIV_LO, 8'd9);
    bus_write(ADDR_CTRL, 8'h01);
    bus_write(ADDR_TXDATA, 8'h00);
    w = 0;
    while (tx !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("reset_test_tx_low", 16'(tx), 16'h0);
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset_tx", 16'(tx), 16'h1);
    check("async_reset_rdata", 16'(r_data), 16'h0);
    mdl_rx.delete(); mdl_tx.delete();
    mdl_ovr = 1'b0; mdl_par = 1'b0; mdl_frm = 1'b0; cur_div = 16'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rd_status(8'hFF, "status_after_mid_reset");
    bus_read(ADDR_CTRL, 8'h00, 8'hFF, "ctrl_after_mid_reset");
    bus_read(ADDR_DIV_LO, 8'h00, 8'hFF, "div_after_mid_reset");
    check("tx_idle_after_reset", 16'(tx), 16'h1);
    check("irq_after_reset", 16'(irq), 16'h0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 16'(exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
